// File: rtl/inst_seq_pkg.sv
// rtl/inst_seq_pkg.sv - shared state enum, inst field positions and address constants for inst_sequencer
package inst_seq_pkg;

  localparam int INST_W = 35;
  localparam int ADDR_W = 11;

  typedef enum logic [3:0] {
    S_IDLE, S_K_RST, S_W_L0, S_W_LOAD, S_X_L0, S_EXEC, S_DRAIN, S_WB,
    S_O_RST, S_ACC, S_ACC_TAIL, S_RELU, S_OUT, S_DONE
  } state_e;

  localparam int RELU_B     = 34;
  localparam int ACC_B      = 33;
  localparam int CEN_P_B    = 32;
  localparam int WEN_P_B    = 31;
  localparam int A_P_LSB    = 20;
  localparam int CEN_X_B    = 19;
  localparam int WEN_X_B    = 18;
  localparam int A_X_LSB    = 7;
  localparam int OFIFO_RD_B = 6;
  localparam int IFIFO_WR_B = 5;
  localparam int IFIFO_RD_B = 4;
  localparam int L0_RD_B    = 3;
  localparam int L0_WR_B    = 2;
  localparam int EXEC_B     = 1;
  localparam int LOAD_B     = 0;

  // Both memories deselected and in read mode, everything else quiet.
  localparam logic [INST_W-1:0] INST_IDLE = 35'h1800C0000;

  localparam logic [ADDR_W-1:0] WEIGHT_BASE = 11'd1024;

endpackage

// File: rtl/phase_timer.sv
// rtl/phase_timer.sv - loadable down-counter with terminal-count flag for fixed-length phases and gaps
module phase_timer #(
  parameter int WIDTH = 11
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] count,
  output logic             tc
);

  logic [WIDTH-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign count = cnt_q;
  assign tc    = (cnt_q == '0);

endmodule

// File: rtl/inst_sequencer.sv
// rtl/inst_sequencer.sv - drives the core inst bus through per-kij passes and per-onij accumulate/output
// Optional RELU state is enabled by defining INST_SEQ_RELU_EN; gap must be at least 1.
module inst_sequencer
  import inst_seq_pkg::*;
#(
  parameter int col      = 8,
  parameter int row      = 8,
  parameter int len_nij  = 36,
  parameter int len_kij  = 9,
  parameter int len_onij = 16,
  parameter int gap      = 10
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              ofifo_valid,
  input  logic [10:0]       acc_addr,
  input  logic              acc_addr_valid,
  output logic              acc_addr_ready,
  output logic [INST_W-1:0] inst,
  output logic              core_rst,
  output logic              out_strobe,
  output logic              busy,
  output logic              done
);

  localparam logic [ADDR_W-1:0] COL_W   = ADDR_W'(col);
  localparam logic [ADDR_W-1:0] NIJ_W   = ADDR_W'(len_nij);
  localparam logic [ADDR_W-1:0] COL_M1  = ADDR_W'(col - 1);
  localparam logic [ADDR_W-1:0] NIJ_M1  = ADDR_W'(len_nij - 1);
  localparam logic [ADDR_W-1:0] GAP_M1  = ADDR_W'(gap - 1);
  localparam logic [ADDR_W-1:0] DRN_M1  = ADDR_W'(row + col - 1);
  localparam logic [ADDR_W-1:0] KIJ_M1  = ADDR_W'(len_kij - 1);
  localparam logic [ADDR_W-1:0] ONIJ_M1 = ADDR_W'(len_onij - 1);

  state_e              state_q, state_d;
  logic                seg_q, seg_d;
  logic [ADDR_W-1:0]   kij_q, kij_d;
  logic [ADDR_W-1:0]   onij_q, onij_d;
  logic [ADDR_W-1:0]   wcnt_q, wcnt_d;
  logic [ADDR_W-1:0]   hs_cnt_q, hs_cnt_d;
  logic                rd_pend_q, rd_pend_d;
  logic [INST_W-1:0]   inst_q, inst_d;
  logic                core_rst_q, core_rst_d;
  logic                ready_q, ready_d;
  logic                strobe_q, strobe_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;

  logic                tmr_load;
  logic [ADDR_W-1:0]   tmr_val;
  logic [ADDR_W-1:0]   tmr_cnt;
  logic                tmr_tc;
  logic [ADDR_W-1:0]   idx_w, idx_x;
  logic                hs;

  phase_timer #(.WIDTH(ADDR_W)) u_timer (
    .clk      (clk),
    .reset    (reset),
    .load     (tmr_load),
    .load_val (tmr_val),
    .count    (tmr_cnt),
    .tc       (tmr_tc)
  );

  // Timer counts down from len-1, so the word index counts up from 0.
  assign idx_w = COL_M1 - tmr_cnt;
  assign idx_x = NIJ_M1 - tmr_cnt;
  assign hs    = ready_q && acc_addr_valid && (state_q == S_ACC);

  always_comb begin
    state_d    = state_q;
    seg_d      = seg_q;
    kij_d      = kij_q;
    onij_d     = onij_q;
    wcnt_d     = wcnt_q;
    hs_cnt_d   = hs_cnt_q;
    rd_pend_d  = 1'b0;
    inst_d     = INST_IDLE;
    core_rst_d = 1'b0;
    ready_d    = 1'b0;
    strobe_d   = 1'b0;
    done_d     = 1'b0;
    tmr_load   = 1'b0;
    tmr_val    = GAP_M1;

    // The ififo path is owned elsewhere; acc trails each pmem read by one cycle.
    inst_d[IFIFO_WR_B] = 1'b0;
    inst_d[IFIFO_RD_B] = 1'b0;
    inst_d[ACC_B]      = rd_pend_q;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d  = S_K_RST;
          seg_d    = 1'b0;
          kij_d    = '0;
          onij_d   = '0;
          tmr_load = 1'b1;
          tmr_val  = GAP_M1;
        end
      end
      S_K_RST: begin
        if (!seg_q) begin
          core_rst_d = 1'b1;
          if (tmr_tc) begin
            seg_d    = 1'b1;
            tmr_load = 1'b1;
            tmr_val  = '0;
          end
        end else if (tmr_tc) begin
          state_d  = S_W_L0;
          seg_d    = 1'b0;
          tmr_load = 1'b1;
          tmr_val  = COL_M1;
        end
      end
      S_W_L0: begin
        if (!seg_q) begin
          inst_d[CEN_X_B]              = 1'b0;
          inst_d[L0_WR_B]              = 1'b1;
          inst_d[A_X_LSB +: ADDR_W]    = WEIGHT_BASE + kij_q * COL_W + idx_w;
          if (tmr_tc) begin
            seg_d    = 1'b1;
            tmr_load = 1'b1;
            tmr_val  = GAP_M1;
          end
        end else if (tmr_tc) begin
          state_d  = S_W_LOAD;
          seg_d    = 1'b0;
          tmr_load = 1'b1;
          tmr_val  = COL_M1;
        end
      end
      S_W_LOAD: begin
        if (!seg_q) begin
          inst_d[L0_RD_B] = 1'b1;
          inst_d[LOAD_B]  = 1'b1;
          if (tmr_tc) begin
            seg_d    = 1'b1;
            tmr_load = 1'b1;
            tmr_val  = GAP_M1;
          end
        end else if (tmr_tc) begin
          state_d  = S_X_L0;
          seg_d    = 1'b0;
          tmr_load = 1'b1;
          tmr_val  = NIJ_M1;
        end
      end
      S_X_L0: begin
        if (!seg_q) begin
          inst_d[CEN_X_B]           = 1'b0;
          inst_d[L0_WR_B]           = 1'b1;
          inst_d[A_X_LSB +: ADDR_W] = idx_x;
          if (tmr_tc) begin
            seg_d    = 1'b1;
            tmr_load = 1'b1;
            tmr_val  = GAP_M1;
          end
        end else if (tmr_tc) begin
          state_d  = S_EXEC;
          seg_d    = 1'b0;
          tmr_load = 1'b1;
          tmr_val  = NIJ_M1;
        end
      end
      S_EXEC: begin
        if (!seg_q) begin
          inst_d[L0_RD_B] = 1'b1;
          inst_d[EXEC_B]  = 1'b1;
          if (tmr_tc) begin
            seg_d    = 1'b1;
            tmr_load = 1'b1;
            tmr_val  = GAP_M1;
          end
        end else if (tmr_tc) begin
          state_d  = S_DRAIN;
          seg_d    = 1'b0;
          tmr_load = 1'b1;
          tmr_val  = DRN_M1;
        end
      end
      S_DRAIN: begin
        inst_d[L0_RD_B] = 1'b1;
        inst_d[EXEC_B]  = 1'b1;
        if (tmr_tc) begin
          state_d = S_WB;
          wcnt_d  = '0;
        end
      end
      S_WB: begin
        inst_d[OFIFO_RD_B] = 1'b1;
        if (ofifo_valid) begin
          inst_d[CEN_P_B]           = 1'b0;
          inst_d[WEN_P_B]           = 1'b0;
          inst_d[A_P_LSB +: ADDR_W] = kij_q * NIJ_W + wcnt_q;
          wcnt_d                    = wcnt_q + 1'b1;
          if (wcnt_q == NIJ_M1) begin
            if (kij_q == KIJ_M1) begin
              state_d = S_O_RST;
            end else begin
              state_d  = S_K_RST;
              seg_d    = 1'b0;
              kij_d    = kij_q + 1'b1;
              tmr_load = 1'b1;
              tmr_val  = GAP_M1;
            end
          end
        end
      end
      S_O_RST: begin
        core_rst_d = 1'b1;
        state_d    = S_ACC;
        hs_cnt_d   = '0;
        ready_d    = 1'b1;
      end
      S_ACC: begin
        ready_d = 1'b1;
        if (hs) begin
          inst_d[CEN_P_B]           = 1'b0;
          inst_d[A_P_LSB +: ADDR_W] = acc_addr;
          rd_pend_d                 = 1'b1;
          hs_cnt_d                  = hs_cnt_q + 1'b1;
          if (hs_cnt_q == KIJ_M1) begin
            state_d = S_ACC_TAIL;
            ready_d = 1'b0;
          end
        end
      end
      S_ACC_TAIL: begin
`ifdef INST_SEQ_RELU_EN
        state_d = S_RELU;
`else
        state_d = S_OUT;
`endif
      end
      S_RELU: begin
        inst_d[RELU_B] = 1'b1;
        state_d        = S_OUT;
      end
      S_OUT: begin
        strobe_d = 1'b1;
        if (onij_q == ONIJ_M1) begin
          state_d = S_DONE;
        end else begin
          state_d = S_O_RST;
          onij_d  = onij_q + 1'b1;
        end
      end
      S_DONE: begin
        done_d  = 1'b1;
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_IDLE;
      seg_q      <= 1'b0;
      kij_q      <= '0;
      onij_q     <= '0;
      wcnt_q     <= '0;
      hs_cnt_q   <= '0;
      rd_pend_q  <= 1'b0;
      inst_q     <= INST_IDLE;
      core_rst_q <= 1'b0;
      ready_q    <= 1'b0;
      strobe_q   <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      seg_q      <= seg_d;
      kij_q      <= kij_d;
      onij_q     <= onij_d;
      wcnt_q     <= wcnt_d;
      hs_cnt_q   <= hs_cnt_d;
      rd_pend_q  <= rd_pend_d;
      inst_q     <= inst_d;
      core_rst_q <= core_rst_d;
      ready_q    <= ready_d;
      strobe_q   <= strobe_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  assign inst           = inst_q;
  assign core_rst       = core_rst_q;
  assign acc_addr_ready = ready_q;
  assign out_strobe     = strobe_q;
  assign busy           = busy_q;
  assign done           = done_q;

endmodule
